// File: rtl/ram64_arbiter_pkg.sv
// Shared widths and port identifiers for the RAM64 two-master arbiter.
package ram64_arbiter_pkg;

   localparam int unsigned RAM64_AW = 6;
   localparam int unsigned RAM64_DW = 16;

   typedef enum logic {
      PORT0 = 1'b0,
      PORT1 = 1'b1
   } port_t;

   // One-hot grant vector for a given port.
   function automatic logic [1:0] port_onehot(input port_t p);
      logic [1:0] oh;
      oh = '0;
      oh[p] = 1'b1;
      return oh;
   endfunction

endpackage

// File: rtl/ram64_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter: combinational one-hot grant, registered last-served pointer.
module rr_arbiter2
   import ram64_arbiter_pkg::*;
(
   input  logic       clk,
   input  logic       reset_n,
   input  logic [1:0] elig,
   output logic [1:0] g
);

   port_t last;

   always_comb begin
      g = '0;
      unique case (elig)
         2'b01:   g = port_onehot(PORT0);
         2'b10:   g = port_onehot(PORT1);
         // On conflict the port that was not served last wins.
         2'b11:   g = (last == PORT0) ? port_onehot(PORT1) : port_onehot(PORT0);
         default: g = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         last <= PORT1;
      end else if (g[0]) begin
         last <= PORT0;
      end else if (g[1]) begin
         last <= PORT1;
      end
   end

endmodule

// File: rtl/ram64_arbiter.sv
// Shares one single-port RAM64 between two request/ack masters, round-robin,
// with registered ack and read-data per port.
module ram64_arbiter
   import ram64_arbiter_pkg::*;
#(
   parameter int unsigned AW = RAM64_AW,
   parameter int unsigned DW = RAM64_DW
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          req0,
   input  logic          we0,
   input  logic [AW-1:0] addr0,
   input  logic [DW-1:0] wdata0,
   output logic          ack0,
   output logic [DW-1:0] rdata0,
   input  logic          req1,
   input  logic          we1,
   input  logic [AW-1:0] addr1,
   input  logic [DW-1:0] wdata1,
   output logic          ack1,
   output logic [DW-1:0] rdata1,
   output logic          mem_load,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_in,
   input  logic [DW-1:0] mem_out,
   output logic          busy
);

   logic [1:0] elig;
   logic [1:0] g;
   logic       sel_we;

   // A port is never eligible in its own ack cycle.
   assign elig = {req1 & ~ack1, req0 & ~ack0};

   rr_arbiter2 u_rr (
      .clk     (clk),
      .reset_n (reset_n),
      .elig    (elig),
      .g       (g)
   );

   always_comb begin
      mem_addr = '0;
      mem_in   = '0;
      sel_we   = 1'b0;
      if (g[0]) begin
         mem_addr = addr0;
         mem_in   = wdata0;
         sel_we   = we0;
      end else if (g[1]) begin
         mem_addr = addr1;
         mem_in   = wdata1;
         sel_we   = we1;
      end
   end

   assign mem_load = sel_we & reset_n;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         ack0   <= 1'b0;
         ack1   <= 1'b0;
         rdata0 <= '0;
         rdata1 <= '0;
         busy   <= 1'b0;
      end else begin
         ack0 <= g[0];
         ack1 <= g[1];
         busy <= |g;
         if (g[0] && !we0) begin
            rdata0 <= mem_out;
         end
         if (g[1] && !we1) begin
            rdata1 <= mem_out;
         end
      end
   end

endmodule

// File: tb/tb_ram64_arbiter.sv
// Randomized scoreboard bench for ram64_arbiter paired with a behavioural RAM64.
module tb_ram64_arbiter;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        req [2];
   logic        we [2];
   logic [5:0]  addr [2];
   logic [15:0] wdata [2];
   logic        ack0, ack1, mem_load, busy;
   logic [15:0] rdata0, rdata1, mem_in, mem_out;
   logic [5:0]  mem_addr;
   logic        ack_v [2];

   logic [15:0] ram [64] = '{default: '0};

   int vectors = 0;
   int fails = 0;

   // Reference state: what the masters should observe.
   logic [15:0] model_mem [64];
   logic        m_ack [2];
   logic [15:0] m_rdata [2];
   logic        m_busy;
   int          m_last;
   logic [15:0] q0 [$];
   logic [15:0] q1 [$];

   always #5 clk = ~clk;

   assign ack_v[0] = ack0;
   assign ack_v[1] = ack1;

   ram64_arbiter #(.AW(6), .DW(16)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .req0     (req[0]),
      .we0      (we[0]),
      .addr0    (addr[0]),
      .wdata0   (wdata[0]),
      .ack0     (ack0),
      .rdata0   (rdata0),
      .req1     (req[1]),
      .we1      (we[1]),
      .addr1    (addr[1]),
      .wdata1   (wdata[1]),
      .ack1     (ack1),
      .rdata1   (rdata1),
      .mem_load (mem_load),
      .mem_addr (mem_addr),
      .mem_in   (mem_in),
      .mem_out  (mem_out),
      .busy     (busy)
   );

   // RAM64: combinational read, write on rising edge when loaded.
   assign mem_out = ram[mem_addr];
   always @(posedge clk) if (mem_load) ram[mem_addr] <= mem_in;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: serves pending requests by the round-robin rule each edge.
   initial begin
      int gp;
      bit e0, e1;
      for (int i = 0; i < 64; i++) model_mem[i] = '0;
      m_ack = '{1'b0, 1'b0};
      m_rdata = '{16'h0, 16'h0};
      m_busy = 1'b0;
      m_last = 1;
      forever begin
         @(posedge clk);
         if (!reset_n) begin
            chk("mem_load in reset", {31'b0, mem_load}, 0);
            m_ack = '{1'b0, 1'b0};
            m_rdata = '{16'h0, 16'h0};
            m_busy = 1'b0;
            m_last = 1;
            q0.delete();
            q1.delete();
         end else begin
            e0 = req[0] && !m_ack[0];
            e1 = req[1] && !m_ack[1];
            if (e0 && e1) gp = (m_last == 0) ? 1 : 0;
            else if (e0) gp = 0;
            else if (e1) gp = 1;
            else gp = -1;
            if (gp >= 0) begin
               chk("mem_load", {31'b0, mem_load}, {31'b0, we[gp]});
               chk("mem_addr", {26'b0, mem_addr}, {26'b0, addr[gp]});
               if (we[gp]) begin
                  chk("mem_in", {16'b0, mem_in}, {16'b0, wdata[gp]});
                  model_mem[addr[gp]] = wdata[gp];
               end else begin
                  m_rdata[gp] = model_mem[addr[gp]];
               end
               if (gp == 0) q0.push_back(m_rdata[0]);
               else q1.push_back(m_rdata[1]);
               m_last = gp;
            end else begin
               chk("mem_load idle", {31'b0, mem_load}, 0);
            end
            m_ack[0] = (gp == 0);
            m_ack[1] = (gp == 1);
            m_busy = (gp >= 0);
         end
      end
   end

   // Monitor: pops expected data whenever the DUT acknowledges.
   initial begin
      logic [15:0] exp;
      forever begin
         @(negedge clk);
         chk("busy", {31'b0, busy}, {31'b0, m_busy});
         chk("ack0", {31'b0, ack0}, {31'b0, m_ack[0]});
         chk("ack1", {31'b0, ack1}, {31'b0, m_ack[1]});
         if (ack0) begin
            if (q0.size() == 0) chk("ack0 without grant", 1, 0);
            else begin
               exp = q0.pop_front();
               chk("rdata0", {16'b0, rdata0}, {16'b0, exp});
            end
         end
         if (ack1) begin
            if (q1.size() == 0) chk("ack1 without grant", 1, 0);
            else begin
               exp = q1.pop_front();
               chk("rdata1", {16'b0, rdata1}, {16'b0, exp});
            end
         end
      end
   end

   // Present a request at a falling edge and hold it until the ack is seen.
   task automatic drive(input int p, input bit w, input logic [5:0] a, input logic [15:0] d);
      bit got = 0;
      req[p] = 1'b1;
      we[p] = w;
      addr[p] = a;
      wdata[p] = d;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (ack_v[p]) begin
            got = 1;
            break;
         end
      end
      if (!got) begin
         chk($sformatf("ack%0d timeout", p), 0, 1);
         req[p] = 1'b0;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_n = 1'b0;
      req[0] = 1'b0;
      req[1] = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
   endtask

   initial begin
      time t0, t1;
      for (int p = 0; p < 2; p++) begin
         req[p] = 1'b0; we[p] = 1'b0; addr[p] = '0; wdata[p] = '0;
      end

      // Reset then idle
      repeat (2) @(negedge clk);
      chk("reset ack0", {31'b0, ack0}, 0);
      chk("reset ack1", {31'b0, ack1}, 0);
      chk("reset busy", {31'b0, busy}, 0);
      chk("reset mem_load", {31'b0, mem_load}, 0);
      chk("reset rdata0", {16'b0, rdata0}, 0);
      chk("reset rdata1", {16'b0, rdata1}, 0);
      reset_n = 1'b1;
      @(negedge clk);

      // Port 0 write then read back
      drive(0, 1'b1, 6'd5, 16'h1234);
      drive(0, 1'b0, 6'd5, 16'h0);
      chk("readback addr5", {16'b0, rdata0}, 32'h1234);
      req[0] = 1'b0;
      @(negedge clk);

      // Contention after reset: port 0 first, then strict alternation
      do_reset();
      fork
         begin
            for (int i = 0; i < 6; i++) begin
               drive(0, 1'b1, 6'd1, 16'($urandom));
               if (i == 0) t0 = $time;
            end
            req[0] = 1'b0;
         end
         begin
            for (int i = 0; i < 6; i++) begin
               drive(1, 1'b1, 6'd2, 16'($urandom));
               if (i == 0) t1 = $time;
            end
            req[1] = 1'b0;
         end
      join
      chk("first grant port0", {31'b0, t0 < t1}, 1);
      @(negedge clk);

      // Same address: port 0 write wins, port 1 read sees new data
      do_reset();
      fork
         begin drive(0, 1'b1, 6'd9, 16'hAAAA); req[0] = 1'b0; end
         begin drive(1, 1'b0, 6'd9, 16'h0); chk("same-addr rdata1", {16'b0, rdata1}, 32'hAAAA); req[1] = 1'b0; end
      join
      @(negedge clk);

      // Reset during a granted write: no RAM update, no ack
      req[1] = 1'b1; we[1] = 1'b1; addr[1] = 6'd20; wdata[1] = 16'hBEEF;
      reset_n = 1'b0;
      #1 chk("mem_load forced low", {31'b0, mem_load}, 0);
      @(negedge clk);
      chk("no ack1 after reset", {31'b0, ack1}, 0);
      req[1] = 1'b0;
      reset_n = 1'b1;
      @(negedge clk);
      chk("ram[20] unchanged", {16'b0, ram[20]}, {16'b0, model_mem[20]});

      // Sweep: port 1 fills, port 0 reads back including the 63->0 wrap
      for (int a = 0; a < 64; a++) drive(1, 1'b1, 6'(a), 16'(a));
      req[1] = 1'b0;
      for (int a = 0; a < 65; a++) begin
         drive(0, 1'b0, 6'(a), 16'h0);
         chk("sweep rdata0", {16'b0, rdata0}, 32'(a % 64));
      end
      req[0] = 1'b0;
      @(negedge clk);

      // Random traffic on a narrow address window to force collisions
      fork
         for (int i = 0; i < 150; i++) begin
            int gap;
            drive(0, 1'($urandom), 6'($urandom_range(0, 7)), 16'($urandom));
            gap = $urandom_range(0, 2);
            if (gap > 0) begin
               req[0] = 1'b0;
               repeat (gap) @(negedge clk);
            end
         end
         for (int i = 0; i < 150; i++) begin
            int gap;
            drive(1, 1'($urandom), 6'($urandom_range(0, 7)), 16'($urandom));
            gap = $urandom_range(0, 2);
            if (gap > 0) begin
               req[1] = 1'b0;
               repeat (gap) @(negedge clk);
            end
         end
      join
      req[0] = 1'b0;
      req[1] = 1'b0;
      repeat (3) @(negedge clk);

      for (int a = 0; a < 64; a++) chk($sformatf("ram[%0d]", a), {16'b0, ram[a]}, {16'b0, model_mem[a]});
      chk("q0 drained", q0.size(), 0);
      chk("q1 drained", q1.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
